// File: rtl/sort_floats_iter_pkg.sv
// Shared types and FP64 helpers for the iterative float sorter.
package sort_floats_pkg;

    localparam int FLEN   = 64;
    localparam int MANT_W = 52;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // NaN: exponent all ones with a non-zero mantissa; infinities compare normally.
    function automatic logic is_nan(input logic [FLEN-1:0] x);
        return (&x[FLEN-2:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

endpackage

// File: rtl/sort_floats_iter_if.sv
// Upstream/downstream valid-ready bundle of the sorter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its payload stay stable until then, ready may change freely.
interface sort_floats_iter_if #(
    parameter int N    = 8,
    parameter int FLEN = 64
);
    logic                     up_valid;
    logic                     up_ready;
    logic [0:N-1][FLEN-1:0]   up_data;
    logic                     down_valid;
    logic                     down_ready;
    logic [0:N-1][FLEN-1:0]   down_data;
    logic                     down_err;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_err
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_err
    );
endinterface

// File: rtl/sort_floats_iter_f_less_or_equal.sv
// Combinational FP64 a <= b; err flags a NaN operand, and +0/-0 compare equal.
module f_less_or_equal
    import sort_floats_pkg::*;
(
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            res_o,
    output logic            err_o
);
    logic            a_s;
    logic            b_s;
    logic [FLEN-2:0] a_m;
    logic [FLEN-2:0] b_m;

    assign a_s = a_i[FLEN-1];
    assign b_s = b_i[FLEN-1];
    assign a_m = a_i[FLEN-2:0];
    assign b_m = b_i[FLEN-2:0];

    always_comb begin
        res_o = 1'b0;
        err_o = is_nan(a_i) | is_nan(b_i);
        if (!err_o) begin
            if (a_m == '0 && b_m == '0) begin
                res_o = 1'b1;
            end else if (a_s != b_s) begin
                res_o = a_s;
            end else if (!a_s) begin
                res_o = (a_m <= b_m);
            end else begin
                // Both negative: larger magnitude is the smaller value.
                res_o = (a_m >= b_m);
            end
        end
    end
endmodule

// File: rtl/sort_floats_iter.sv
// Iterative bubble sorter: one comparator, one compare per cycle, early exit on a clean pass.
module sort_floats_iter
    import sort_floats_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_floats_iter_if.slave bus,
    output state_t            state_o
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LIMIT_INIT = CW'(N - 1);

    typedef logic [0:N-1][FLEN-1:0] vec_t;

    state_t          state_q;
    vec_t            buf_q;
    vec_t            buf_d;
    vec_t            down_data_q;
    logic [CW-1:0]   j_q;
    logic [CW-1:0]   j_nx;
    logic [CW-1:0]   limit_q;
    logic            swapped_q;
    logic            up_ready_q;
    logic            down_valid_q;
    logic            down_err_q;
    logic [FLEN-1:0] cmp_a;
    logic [FLEN-1:0] cmp_b;
    logic            cmp_res;
    logic            cmp_err;
    logic            do_swap;
    logic            pass_end;

    assign j_nx     = j_q + 1'b1;
    assign cmp_a    = buf_q[j_q];
    assign cmp_b    = buf_q[j_nx];
    assign do_swap  = (state_q == SORT) && !cmp_err && !cmp_res;
    assign pass_end = (j_q == limit_q - 1'b1);

    f_less_or_equal u_cmp (
        .a_i   (cmp_a),
        .b_i   (cmp_b),
        .res_o (cmp_res),
        .err_o (cmp_err)
    );

    always_comb begin
        buf_d = buf_q;
        if (do_swap) begin
            buf_d[j_q]  = cmp_b;
            buf_d[j_nx] = cmp_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            down_data_q  <= '0;
            j_q          <= '0;
            limit_q      <= '0;
            swapped_q    <= 1'b0;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
            down_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.up_valid) begin
                        buf_q      <= bus.up_data;
                        j_q        <= '0;
                        limit_q    <= LIMIT_INIT;
                        swapped_q  <= 1'b0;
                        up_ready_q <= 1'b0;
                        state_q    <= SORT;
                    end
                end
                SORT: begin
                    buf_q <= buf_d;
                    // Outputs are captured only here so they never move while a sort runs.
                    if (cmp_err || (pass_end && (!(swapped_q || do_swap) || limit_q == 1))) begin
                        state_q      <= DONE;
                        down_valid_q <= 1'b1;
                        down_data_q  <= buf_d;
                        down_err_q   <= cmp_err;
                    end else if (pass_end) begin
                        limit_q   <= limit_q - 1'b1;
                        j_q       <= '0;
                        swapped_q <= 1'b0;
                    end else begin
                        j_q       <= j_nx;
                        swapped_q <= swapped_q | do_swap;
                    end
                end
                DONE: begin
                    if (bus.down_ready) begin
                        down_valid_q <= 1'b0;
                        up_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.up_ready   = up_ready_q;
    assign bus.down_valid = down_valid_q;
    assign bus.down_data  = down_data_q;
    assign bus.down_err   = down_err_q;
    assign state_o        = state_q;
endmodule
